// File: rtl/sdram_tg_pkg.sv
// rtl/sdram_tg_pkg.sv - shared types and helpers for the SDRAM traffic generator
// Purpose: FSM state type, run-mode constants and the xorshift32 step used by
// both the write-data and expected-data generators. No ports.
package sdram_tg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR,
    ST_LANE_WR,
    ST_RD,
    ST_WAIT_RV,
    ST_BWR,
    ST_BRD,
    ST_DRAIN,
    ST_DONE
  } tg_state_t;

  localparam logic MODE_INTERLEAVED = 1'b0;
  localparam logic MODE_BLOCK       = 1'b1;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/sdram_tg_prng.sv
// rtl/sdram_tg_prng.sv - seeded xorshift32 register with load and advance
// Ports: clk_i/rst_ni clock and async active-low reset; load_i reloads SEED
// (wins over adv_i); adv_i steps the generator once; state_o is the current value.
module sdram_tg_prng
  import sdram_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12345
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (adv_i) begin
      state_d = xorshift32(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sdram_traffic_gen.sv
// rtl/sdram_traffic_gen.sv - write/read traffic generator and checker for the SDRAM controller port
// Ports: start_i/mode_i/lane_test_i run control; addr_o/write_data_o/wr_o/rd_o
// request with rdy_i acceptance; rvalid_i/read_data_i in-order read returns;
// busy_o/done_o/pass_o/err_count_o/first_err_addr_o/proto_err_o run results.
module sdram_traffic_gen
  import sdram_tg_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           NUM_WORDS       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned           MAX_OUTSTANDING = 4,
  parameter logic [31:0]           SEED            = 32'hACE12345
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic                    lane_test_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   write_data_o,
  output logic [DATA_WIDTH/8-1:0] wr_o,
  output logic                    rd_o,
  input  logic                    rdy_i,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   read_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             err_count_o,
  output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
  output logic                    proto_err_o
);

  localparam int unsigned           NB        = DATA_WIDTH / 8;
  localparam int unsigned           IDXW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(NUM_WORDS - 1);
  localparam logic [3:0]            MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(NB);

  tg_state_t             state_q, state_d;
  logic                  lane_q;
  logic [IDXW-1:0]       idx_q;
  logic [ADDR_WIDTH-1:0] req_addr_q, cmp_addr_q, first_q;
  logic [3:0]            out_q;
  logic [15:0]           err_q;
  logic                  proto_q;

  logic [31:0]           wgen_state, egen_state;
  logic [DATA_WIDTH-1:0] wdata, exp_word, lane_mask;
  logic [NB-1:0]         lane_be;
  logic [1:0]            lane_sel;
  logic                  start_ok, wr_acc, rd_acc, rv_ok, last_word, wgen_adv;

  assign start_ok  = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign wr_acc    = (wr_o != '0) && rdy_i;
  assign rd_acc    = rd_o && rdy_i;
  // A return only counts when a read is actually owed; anything else is a protocol error.
  assign rv_ok     = rvalid_i && (out_q != '0) && (state_q inside {ST_WAIT_RV, ST_BRD, ST_DRAIN});
  assign last_word = (idx_q == LAST_IDX);
  assign wgen_adv  = (state_q == ST_WAIT_RV && rv_ok) || (state_q == ST_BWR && wr_acc);

  sdram_tg_prng #(.SEED(SEED)) u_wgen (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(start_ok), .adv_i(wgen_adv), .state_o(wgen_state)
  );
  sdram_tg_prng #(.SEED(SEED)) u_egen (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(start_ok), .adv_i(rv_ok), .state_o(egen_state)
  );

  assign wdata    = wgen_state[DATA_WIDTH-1:0];
  assign lane_sel = 2'(32'(idx_q) % NB);
  assign lane_be  = NB'(1) << lane_sel;

  // Expected data after a lane-merge write: the merged lane holds the inverted byte.
  always_comb begin
    lane_mask = '0;
    for (int l = 0; l < NB; l++) begin
      if (lane_be[l]) lane_mask[8*l +: 8] = 8'hFF;
    end
  end
  assign exp_word = egen_state[DATA_WIDTH-1:0] ^ (lane_q ? lane_mask : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = (mode_i == MODE_BLOCK) ? ST_BWR : ST_WR;
      ST_WR:            if (wr_acc) state_d = lane_q ? ST_LANE_WR : ST_RD;
      ST_LANE_WR:       if (wr_acc) state_d = ST_RD;
      ST_RD:            if (rd_acc) state_d = ST_WAIT_RV;
      ST_WAIT_RV:       if (rv_ok) state_d = last_word ? ST_DONE : ST_WR;
      ST_BWR:           if (wr_acc && last_word) state_d = ST_BRD;
      ST_BRD:           if (rd_acc && last_word) state_d = ST_DRAIN;
      ST_DRAIN:         if (out_q == '0) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_o       = '0;
    write_data_o = '0;
    wr_o         = '0;
    rd_o         = 1'b0;
    case (state_q)
      ST_WR, ST_BWR: begin
        addr_o       = req_addr_q;
        write_data_o = wdata;
        wr_o         = '1;
      end
      ST_LANE_WR: begin
        addr_o       = req_addr_q;
        write_data_o = ~wdata;
        wr_o         = lane_be;
      end
      ST_RD: begin
        addr_o = req_addr_q;
        rd_o   = 1'b1;
      end
      // Address stays on the bus while throttled so the next read is ready to go.
      ST_BRD: begin
        addr_o = req_addr_q;
        rd_o   = (out_q < MAX_OUT);
      end
      default: ;
    endcase
  end

  assign busy_o           = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign done_o           = (state_q == ST_DONE);
  assign pass_o           = done_o && (err_q == '0) && !proto_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign proto_err_o      = proto_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q     <= 1'b0;
      idx_q      <= '0;
      req_addr_q <= '0;
      cmp_addr_q <= '0;
      first_q    <= '0;
      out_q      <= '0;
      err_q      <= '0;
      proto_q    <= 1'b0;
    end else begin
      out_q <= out_q + 4'(rd_acc) - 4'(rv_ok);
      if (rvalid_i && !rv_ok) proto_q <= 1'b1;

      if (start_ok) begin
        lane_q     <= lane_test_i && (mode_i == MODE_INTERLEAVED);
        idx_q      <= '0;
        req_addr_q <= BASE_ADDR;
        cmp_addr_q <= BASE_ADDR;
        first_q    <= '0;
        err_q      <= '0;
        proto_q    <= 1'b0;
      end

      // Request-side word index: per compare in interleaved mode, per accept in block mode.
      if ((state_q == ST_WAIT_RV && rv_ok) || (state_q == ST_BWR && wr_acc) ||
          (state_q == ST_BRD && rd_acc)) begin
        if (state_q == ST_BWR && last_word) begin
          idx_q      <= '0;
          req_addr_q <= BASE_ADDR;
        end else if (!last_word) begin
          idx_q      <= idx_q + 1'b1;
          req_addr_q <= req_addr_q + ADDR_STEP;
        end
      end

      if (rv_ok) begin
        cmp_addr_q <= cmp_addr_q + ADDR_STEP;
        if (read_data_i != exp_word) begin
          if (err_q == '0) first_q <= cmp_addr_q;
          if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb/tb_sdram_traffic_gen.sv - self-checking bench for sdram_traffic_gen
module tb_sdram_traffic_gen;

  localparam int          NW   = 16;
  localparam int          MAXO = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] SEED = 32'hACE12345;

  logic        clk, rst_n, start, mode, lane_test, rdy, rvalid;
  logic [31:0] read_data, addr, write_data, first_err_addr;
  logic [3:0]  wr;
  logic        rd, busy, done, pass, proto_err;
  logic [15:0] err_count;

  sdram_traffic_gen #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(NW), .BASE_ADDR(BASE),
    .MAX_OUTSTANDING(MAXO), .SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .lane_test_i(lane_test),
    .addr_o(addr), .write_data_o(write_data), .wr_o(wr), .rd_o(rd), .rdy_i(rdy),
    .rvalid_i(rvalid), .read_data_i(read_data), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .first_err_addr_o(first_err_addr), .proto_err_o(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;
  typedef struct {
    longint      due;
    logic [31:0] data;
  } ret_t;

  req_t        exp_q[$];
  ret_t        pend[$];
  logic [31:0] mem[logic [31:0]];

  int          n_vec = 0, n_miss = 0;
  int          rdy_pct, lat, inflight, max_if, n_ret, n_rd_acc, exp_err;
  logic [31:0] exp_first;
  logic [NW-1:0] corrupt;
  bit          spur_pend;
  longint      cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] v);
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  // Memory responder: observes the request at the negedge, decides rdy for the
  // coming posedge, and returns reads in order after a fixed latency.
  task automatic accept();
    req_t        e;
    logic [31:0] v;
    int          widx;
    if (exp_q.size() == 0) begin
      check("extra_req", (wr != 0) || rd, 0);
      return;
    end
    e = exp_q.pop_front();
    check("req_kind", rd, e.is_rd);
    check("req_addr", addr, e.addr);
    check("wr_rd_excl", (wr != 0) && rd, 0);
    v = mem.exists(addr) ? mem[addr] : 32'h0;
    if (!e.is_rd) begin
      check("wr_data", write_data, e.data);
      check("wr_be", wr, e.be);
      for (int l = 0; l < 4; l++) if (wr[l]) v[8*l +: 8] = write_data[8*l +: 8];
      mem[addr] = v;
    end else begin
      widx = int'((addr - BASE) >> 2);
      if (widx >= 0 && widx < NW && corrupt[widx]) v[0] = ~v[0];
      pend.push_back('{due: cyc + lat, data: v});
      inflight++;
      n_rd_acc++;
      if (inflight > max_if) max_if = inflight;
    end
  endtask

  initial begin
    bit          have_prev, req_now;
    logic [31:0] prev_addr;
    logic [36:0] prev_ctl;
    have_prev = 0;
    rdy = 1'b0; rvalid = 1'b0; read_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      rvalid = 1'b0;
      if (!rst_n) begin
        pend.delete();
        inflight = 0;
        rdy = 1'b0;
        have_prev = 0;
      end else begin
        req_now = (wr != 0) || rd;
        if (have_prev) begin
          check("stall_addr", addr, prev_addr);
          check("stall_ctl", {wr, rd, write_data}, prev_ctl);
        end
        if (rd) check("rd_below_max", inflight < MAXO, 1);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        if (req_now && rdy) accept();
        have_prev = req_now && !rdy;
        prev_addr = addr;
        prev_ctl  = {wr, rd, write_data};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          rvalid    = 1'b1;
          read_data = pend[0].data;
          void'(pend.pop_front());
          inflight--;
          n_ret++;
        end else if (spur_pend && inflight == 0 && wr != 0) begin
          rvalid    = 1'b1;
          read_data = $urandom;
          spur_pend = 0;
        end
      end
    end
  end

  // Reference: address i -> BASE+4i, data D(i) from a freshly seeded xorshift32,
  // request order per mode, and mismatches only where the memory corrupts a word.
  task automatic prepare(input bit m, input bit lt, input int pct, input int l,
                         input logic [NW-1:0] cm, input bit sp);
    logic [31:0] x, dv;
    req_t        e;
    bit          lane;
    exp_q.delete();
    mem.delete();
    rdy_pct = pct; lat = l; corrupt = cm; spur_pend = sp;
    max_if = 0; n_ret = 0; n_rd_acc = 0;
    mode = m; lane_test = lt;
    lane = lt && !m;
    x = SEED;
    for (int i = 0; i < NW; i++) begin
      dv = x;
      x  = xs(x);
      e = '{is_rd: 0, addr: BASE + 32'(i * 4), data: dv, be: 4'hF};
      exp_q.push_back(e);
      if (!m) begin
        if (lane) begin
          e.data = ~dv;
          e.be   = 4'(1 << (i % 4));
          exp_q.push_back(e);
        end
        exp_q.push_back('{is_rd: 1, addr: BASE + 32'(i * 4), data: '0, be: '0});
      end
    end
    if (m) for (int i = 0; i < NW; i++)
      exp_q.push_back('{is_rd: 1, addr: BASE + 32'(i * 4), data: '0, be: '0});
    exp_err = $countones(cm);
    exp_first = '0;
    for (int i = NW - 1; i >= 0; i--) if (cm[i]) exp_first = BASE + 32'(i * 4);
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run(input bit m, input bit lt, input int pct, input int l,
                     input logic [NW-1:0] cm, input bit sp);
    int k;
    prepare(m, lt, pct, l, cm, sp);
    kick();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    repeat (2) @(negedge clk);
    check("done_held", done, 1);
    check("pass", pass, (exp_err == 0) && !sp);
    check("err_count", err_count, exp_err);
    check("first_err_addr", first_err_addr, exp_first);
    check("proto_err", proto_err, sp);
    check("busy_at_done", busy, 0);
    check("req_at_done", {wr, rd}, 0);
    check("reqs_left", exp_q.size(), 0);
    check("rets_left", pend.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wdata"}, write_data, 0);
    check({tag, "_wr"}, wr, 0);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_first"}, first_err_addr, 0);
    check({tag, "_proto"}, proto_err, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; lane_test = 1'b0;
    rdy_pct = 100; lat = 1; corrupt = '0; spur_pend = 0;
    inflight = 0; max_if = 0; n_ret = 0; n_rd_acc = 0; exp_err = 0; exp_first = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    run(0, 0, 100, 1, '0, 0);
    run(0, 1, 100, 2, '0, 0);
    run(1, 0, 100, 6, '0, 0);
    check("max_inflight", max_if, MAXO);
    run(0, 0, 100, 1, 16'h0020, 0);
    run(0, 1, 50, 3, '0, 0);
    run(1, 1, 50, 4, 16'h1200, 0);
    run(0, 0, 100, 1, '0, 1);

    prepare(1, 0, 100, 6, 16'h0001, 0);
    kick();
    k = 0;
    while (n_ret < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("mid_brd_returns", n_ret >= 2, 1);
    check("mid_brd_reads_left", n_rd_acc < NW, 1);
    check("err_before_reset", err_count, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check("reset_no_req", {wr, rd}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("idle_after_reset", busy, 0);

    run(1, 0, 70, 2, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
